// File: rtl/skew_buf_pkg.sv
// Shared types for the double-buffered skewed operand buffer.
// Bank/stream state encodings and the per-matrix stream length.
package skew_buf_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      FULL,
      STREAMING
   } bank_state_t;

   typedef enum logic {
      IDLE,
      RUN
   } stream_state_t;

   function automatic int STREAM_LEN(input int dim);
      return 2 * dim - 1;
   endfunction

endpackage

// File: rtl/skew_bank.sv
// One DIM x DIM operand bank: row write port, written-row mask,
// stored stream mode and a combinational skewed read at step t.
module skew_bank
   import skew_buf_pkg::*;
#(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8,
   parameter int RW      = $clog2(DIM),
   parameter int TW      = $clog2(STREAM_LEN(DIM))
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [RW-1:0]             wr_row,
   input  logic signed [BITS_AB-1:0] wr_data [DIM],
   input  logic                      commit,
   input  logic                      mode_col,
   input  logic                      clear,
   input  logic [TW-1:0]             t,
   output logic signed [BITS_AB-1:0] rd_data [DIM]
);

   logic signed [BITS_AB-1:0] mem [DIM][DIM];
   logic [DIM-1:0]            written;
   logic                      col;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_row] <= wr_data;
      end
   end

   // Unwritten rows are masked on read, so storage needs no reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         written <= '0;
         col     <= 1'b0;
      end else begin
         if (clear) begin
            written <= '0;
         end else if (wr_en) begin
            written[wr_row] <= 1'b1;
         end
         if (commit) begin
            col <= mode_col;
         end
      end
   end

   for (genvar i = 0; i < DIM; i++) begin : g_lane
      logic [TW-1:0]             k;
      logic                      in_win;
      logic signed [BITS_AB-1:0] v;

      always_comb begin
         k      = t - TW'(i);
         in_win = (t >= TW'(i)) && (k < TW'(DIM));
         v      = '0;
         if (in_win) begin
            if (col) begin
               if (written[RW'(k)]) begin
                  v = mem[RW'(k)][i];
               end
            end else if (written[i]) begin
               v = mem[i][RW'(k)];
            end
         end
      end

      assign rd_data[i] = v;
   end

endmodule

// File: rtl/skew_pingpong_buf.sv
// Ping-pong skewed A-operand buffer: one bank loads while the
// other streams its wavefront, matrices run back-to-back.
module skew_pingpong_buf
   import skew_buf_pkg::*;
#(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [$clog2(DIM)-1:0]    wr_row,
   input  logic signed [BITS_AB-1:0] wr_data [DIM],
   input  logic                      wr_commit,
   input  logic                      wr_mode_col,
   output logic                      ld_ready,
   input  logic                      out_en,
   output logic                      out_valid,
   output logic                      out_first,
   output logic                      out_last,
   output logic signed [BITS_AB-1:0] out_data [DIM],
   output logic                      wr_err
);

   localparam int RW = $clog2(DIM);
   localparam int TW = $clog2(STREAM_LEN(DIM));
   localparam logic [TW-1:0] T_LAST = TW'(STREAM_LEN(DIM) - 1);

   bank_state_t   bank_st   [2];
   bank_state_t   bank_st_n [2];
   stream_state_t st, st_n;

   logic          wbank, wbank_n;
   logic          rbank, rbank_n;
   logic [TW-1:0] t, t_n;

   logic wr_ok, cm_ok, emit;
   logic [1:0] clr;
   logic valid_n, first_n, last_n, err_n;

   logic signed [BITS_AB-1:0] rd0    [DIM];
   logic signed [BITS_AB-1:0] rd1    [DIM];
   logic signed [BITS_AB-1:0] sel    [DIM];
   logic signed [BITS_AB-1:0] data_n [DIM];

   assign ld_ready = (bank_st[wbank] == EMPTY);
   assign wr_ok    = wr_en & ld_ready;
   assign cm_ok    = wr_commit & ld_ready;

   skew_bank #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM),
      .RW      (RW),
      .TW      (TW)
   ) u_bank0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_ok & ~wbank),
      .wr_row   (wr_row),
      .wr_data  (wr_data),
      .commit   (cm_ok & ~wbank),
      .mode_col (wr_mode_col),
      .clear    (clr[0]),
      .t        (t),
      .rd_data  (rd0)
   );

   skew_bank #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM),
      .RW      (RW),
      .TW      (TW)
   ) u_bank1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_ok & wbank),
      .wr_row   (wr_row),
      .wr_data  (wr_data),
      .commit   (cm_ok & wbank),
      .mode_col (wr_mode_col),
      .clear    (clr[1]),
      .t        (t),
      .rd_data  (rd1)
   );

   for (genvar i = 0; i < DIM; i++) begin : g_sel
      assign sel[i] = rbank ? rd1[i] : rd0[i];
   end

   // Commit only touches an EMPTY bank and streaming only a
   // FULL/STREAMING one, so the two updates never collide.
   always_comb begin
      st_n      = st;
      t_n       = t;
      wbank_n   = wbank;
      rbank_n   = rbank;
      bank_st_n = bank_st;
      valid_n   = 1'b0;
      first_n   = 1'b0;
      last_n    = 1'b0;
      data_n    = out_data;
      err_n     = wr_err;
      emit      = 1'b0;
      clr       = '0;

      if ((wr_en | wr_commit) & ~ld_ready) begin
         err_n = 1'b1;
      end

      if (cm_ok) begin
         bank_st_n[wbank] = FULL;
         wbank_n          = ~wbank;
      end

      if (out_en) begin
         unique case (st)
            IDLE: begin
               if (bank_st[rbank] == FULL) begin
                  emit             = 1'b1;
                  bank_st_n[rbank] = STREAMING;
                  st_n             = RUN;
               end
            end
            RUN: emit = 1'b1;
            default: ;
         endcase
      end

      // t is 0 whenever the FSM sits in IDLE.
      if (emit) begin
         data_n  = sel;
         valid_n = 1'b1;
         first_n = (t == '0);
         last_n  = (t == T_LAST);
         if (t == T_LAST) begin
            bank_st_n[rbank] = EMPTY;
            clr[rbank]       = 1'b1;
            rbank_n          = ~rbank;
            st_n             = IDLE;
            t_n              = '0;
         end else begin
            t_n = t + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_st   <= '{EMPTY, EMPTY};
         st        <= IDLE;
         wbank     <= 1'b0;
         rbank     <= 1'b0;
         t         <= '0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '{default: '0};
         wr_err    <= 1'b0;
      end else begin
         bank_st   <= bank_st_n;
         st        <= st_n;
         wbank     <= wbank_n;
         rbank     <= rbank_n;
         t         <= t_n;
         out_valid <= valid_n;
         out_first <= first_n;
         out_last  <= last_n;
         out_data  <= data_n;
         wr_err    <= err_n;
      end
   end

endmodule

// File: tb/tb_skew_pingpong_buf.sv
// Bench for skew_pingpong_buf: directed scenarios plus random traffic
// checked against a queue-of-matrices reference model.
module tb_skew_pingpong_buf;

   localparam int DIM = 4;
   localparam int BITS_AB = 8;
   localparam int RW = 2;
   localparam int LEN = 2 * DIM - 1;
   localparam int MW = DIM * DIM * BITS_AB;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic wr_en = 1'b0;
   logic wr_commit = 1'b0;
   logic wr_mode_col = 1'b0;
   logic out_en = 1'b0;
   logic [RW-1:0] wr_row = '0;
   logic signed [BITS_AB-1:0] wr_data [DIM];
   logic ld_ready, out_valid, out_first, out_last, wr_err;
   logic signed [BITS_AB-1:0] out_data [DIM];

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic          col;
      logic [MW-1:0] a;
   } mat_t;

   mat_t          q[$];
   logic [MW-1:0] lm;
   int            tcur;
   int            exp_data [DIM];
   bit exp_valid, exp_first, exp_last, exp_err, exp_ready;

   skew_pingpong_buf #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_row      (wr_row),
      .wr_data     (wr_data),
      .wr_commit   (wr_commit),
      .wr_mode_col (wr_mode_col),
      .ld_ready    (ld_ready),
      .out_en      (out_en),
      .out_valid   (out_valid),
      .out_first   (out_first),
      .out_last    (out_last),
      .out_data    (out_data),
      .wr_err      (wr_err)
   );

   always #5 clk = ~clk;

   function automatic int el(input mat_t m, input int r, input int c);
      logic signed [BITS_AB-1:0] v;
      v = m.a[(r * DIM + c) * BITS_AB +: BITS_AB];
      return int'(v);
   endfunction

   task automatic model_reset();
      q.delete();
      lm = '0;
      tcur = 0;
      exp_valid = 0;
      exp_first = 0;
      exp_last = 0;
      exp_err = 0;
      exp_ready = 1;
      for (int i = 0; i < DIM; i++) exp_data[i] = 0;
   endtask

   // Applies the spec rules for one clock edge using the inputs the DUT saw.
   task automatic model_edge();
      bit   rdy;
      mat_t m;
      int   k;
      rdy = (q.size() < 2);
      exp_valid = 0;
      exp_first = 0;
      exp_last = 0;
      if (out_en && q.size() > 0) begin
         m = q[0];
         for (int i = 0; i < DIM; i++) begin
            k = tcur - i;
            if (k >= 0 && k < DIM)
               exp_data[i] = m.col ? el(m, k, i) : el(m, i, k);
            else
               exp_data[i] = 0;
         end
         exp_valid = 1;
         exp_first = (tcur == 0);
         exp_last = (tcur == LEN - 1);
         if (tcur == LEN - 1) begin
            void'(q.pop_front());
            tcur = 0;
         end else begin
            tcur++;
         end
      end
      if ((wr_en || wr_commit) && !rdy) exp_err = 1;
      if (wr_en && rdy)
         for (int c = 0; c < DIM; c++)
            lm[(int'(wr_row) * DIM + c) * BITS_AB +: BITS_AB] = wr_data[c];
      if (wr_commit && rdy) begin
         m.col = wr_mode_col;
         m.a = lm;
         q.push_back(m);
         lm = '0;
      end
      exp_ready = (q.size() < 2);
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input int e [DIM]);
      for (int i = 0; i < DIM; i++) chk($sformatf("%s_lane%0d", tag, i), out_data[i], e[i]);
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_valid"}, out_valid, exp_valid);
      chk({tag, "_first"}, out_first, exp_first);
      chk({tag, "_last"}, out_last, exp_last);
      chk({tag, "_ready"}, ld_ready, exp_ready);
      chk({tag, "_err"}, wr_err, exp_err);
      for (int i = 0; i < DIM; i++)
         chk($sformatf("%s_data%0d", tag, i), out_data[i], exp_data[i]);
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic write_row(input string tag, input int r, input int v [DIM]);
      wr_en = 1;
      wr_row = RW'(r);
      for (int c = 0; c < DIM; c++) wr_data[c] = BITS_AB'(v[c]);
      cycle(tag);
      wr_en = 0;
   endtask

   task automatic write_rand(input string tag, input int r);
      int v [DIM];
      for (int c = 0; c < DIM; c++) v[c] = int'($urandom_range(0, 255)) - 128;
      write_row(tag, r, v);
   endtask

   task automatic write_mat1(input string tag);
      int v [DIM];
      for (int r = 0; r < DIM; r++) begin
         for (int c = 0; c < DIM; c++) v[c] = 4 * r + c + 1;
         write_row(tag, r, v);
      end
   endtask

   task automatic do_commit(input string tag, input logic col);
      wr_commit = 1;
      wr_mode_col = col;
      cycle(tag);
      wr_commit = 0;
   endtask

   initial begin
      int nvalid;
      for (int i = 0; i < DIM; i++) wr_data[i] = '0;
      model_reset();
      #1 rst_n = 0;
      #1 check_all("reset_hold");
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      cycle("post_reset");

      // Row-mode wavefront of A[i][k] = 4i+k+1
      write_mat1("t1_load");
      do_commit("t1_commit", 1'b0);
      out_en = 1;
      for (int s = 0; s < LEN; s++) begin
         cycle("t1_stream");
         chk("t1_first_c", out_first, s == 0);
         chk("t1_last_c", out_last, s == LEN - 1);
         if (s == 0) chk_vec("t1_s0", '{1, 0, 0, 0});
         if (s == 1) chk_vec("t1_s1", '{2, 5, 0, 0});
         if (s == 3) chk_vec("t1_s3", '{4, 7, 10, 13});
         if (s == 6) chk_vec("t1_s6", '{0, 0, 0, 16});
      end
      out_en = 0;
      cycle("t1_idle");

      // Transposed streaming of the same matrix
      write_mat1("t2_load");
      do_commit("t2_commit", 1'b1);
      out_en = 1;
      for (int s = 0; s < LEN; s++) begin
         cycle("t2_stream");
         if (s == 1) chk_vec("t2_s1", '{5, 2, 0, 0});
         if (s == 3) chk_vec("t2_s3", '{13, 10, 7, 4});
      end
      out_en = 0;

      // Ping-pong: load M2 while M1 streams, then overfill
      for (int r = 0; r < DIM; r++) write_rand("t3_m1", r);
      do_commit("t3_m1c", 1'($urandom_range(0, 1)));
      out_en = 1;
      nvalid = 0;
      for (int r = 0; r < DIM; r++) begin
         write_rand("t3_m2", r);
         nvalid += int'(out_valid);
      end
      do_commit("t3_m2c", 1'($urandom_range(0, 1)));
      nvalid += int'(out_valid);
      chk("t3_ready_full", ld_ready, 0);
      write_rand("t3_over", 1);
      nvalid += int'(out_valid);
      chk("t3_err", wr_err, 1);
      for (int s = 0; s < 2 * LEN - DIM - 2; s++) begin
         cycle("t3_stream");
         nvalid += int'(out_valid);
      end
      chk("t3_no_bubble", nvalid, 2 * LEN);
      out_en = 0;
      cycle("t3_idle");

      // Sparse load: rows 1 and 3 never written
      write_rand("t4_load", 0);
      write_rand("t4_load", 2);
      do_commit("t4_commit", 1'b0);
      out_en = 1;
      for (int s = 0; s < LEN; s++) begin
         cycle("t4_stream");
         chk("t4_lane1", out_data[1], 0);
         chk("t4_lane3", out_data[3], 0);
      end
      out_en = 0;

      // Stall at t=2 for three cycles
      write_mat1("t5_load");
      do_commit("t5_commit", 1'b0);
      out_en = 1;
      for (int s = 0; s < 3; s++) cycle("t5_pre");
      out_en = 0;
      for (int s = 0; s < 3; s++) begin
         cycle("t5_stall");
         chk("t5_stall_valid", out_valid, 0);
         chk_vec("t5_hold", '{3, 6, 9, 0});
      end
      out_en = 1;
      cycle("t5_resume");
      chk_vec("t5_s3", '{4, 7, 10, 13});
      for (int s = 4; s < LEN; s++) cycle("t5_post");
      out_en = 0;

      // Reset mid-stream with both banks occupied
      write_mat1("t6_m1");
      do_commit("t6_m1c", 1'b0);
      for (int r = 0; r < DIM; r++) write_rand("t6_m2", r);
      do_commit("t6_m2c", 1'b1);
      out_en = 1;
      for (int s = 0; s < 5; s++) cycle("t6_stream");
      chk("t6_valid_pre", out_valid, 1);
      #2 rst_n = 0;
      model_reset();
      #1 check_all("t6_rst");
      chk_vec("t6_rst_zero", '{0, 0, 0, 0});
      @(negedge clk);
      rst_n = 1;
      for (int s = 0; s < 3; s++) begin
         cycle("t6_after");
         chk("t6_no_valid", out_valid, 0);
      end
      out_en = 0;

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         wr_en = 1'($urandom_range(0, 1));
         wr_row = RW'($urandom_range(0, DIM - 1));
         for (int c = 0; c < DIM; c++) wr_data[c] = BITS_AB'($urandom);
         wr_commit = ($urandom_range(0, 5) == 0);
         wr_mode_col = 1'($urandom_range(0, 1));
         out_en = ($urandom_range(0, 3) != 0);
         cycle("rand");
      end
      wr_en = 0;
      wr_commit = 0;
      out_en = 0;
      cycle("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
